// File: rtl/shift_fifo_thr.sv
// shift_fifo_thr
// Shift-register FIFO: the head always sits in entry 0 and every pop shifts
// the remaining entries one place toward the head, so no read pointer is kept.
// It reports its occupancy and almost-full/almost-empty levels, keeps sticky
// overflow/underflow error flags, and offers a registered read mode or a
// first-word-fall-through read mode.

module shift_fifo_thr #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int AFULL_THR  = 12,
    parameter int AEMPTY_THR = 2,
    parameter bit FWFT       = 1'b0
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                wr_en,
    input  logic [DATA_WIDTH-1:0]               wr_data,
    output logic                                wr_ready,
    input  logic                                rd_en,
    output logic [DATA_WIDTH-1:0]               rd_data,
    output logic                                rd_val,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     count,
    output logic                                almost_full,
    output logic                                almost_empty,
    output logic                                overflow,
    output logic                                underflow,
    input  logic                                err_clr
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THR);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THR);

    // Storage, occupancy, registered read port and sticky error flags.
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];

    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_d;

    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] rd_data_d;
    logic                  rd_val_q;
    logic                  rd_val_d;

    logic                  overflow_q;
    logic                  overflow_d;
    logic                  underflow_q;
    logic                  underflow_d;

    // Handshake decode: what was accepted this cycle.
    logic                  is_empty;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  bypass;
    logic [CW-1:0]         wr_idx;

    // Level feedback is decoded only from the registered count, so the
    // producer never sees a combinational path from the consumer's rd_en.
    always_comb begin
        is_empty     = (count_q == '0);
        wr_ready     = (count_q < DEPTH_C);
        almost_full  = (count_q >= AFULL_C);
        almost_empty = (count_q <= AEMPTY_C);
    end

    // Accept decode. A push while full is rejected even when a pop frees a
    // slot in the same cycle; the bypass path only exists in registered mode.
    always_comb begin
        wr_acc = wr_en && wr_ready;
        rd_acc = rd_en && !is_empty;
        bypass = !FWFT && rd_en && wr_acc && is_empty;
        if (rd_acc) begin
            wr_idx = count_q - CW'(1);
        end else begin
            wr_idx = count_q;
        end
    end

    // Next storage contents: shift toward the head on a pop, then drop the
    // new word into the first free slot (which already reflects the shift).
    always_comb begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (rd_acc) begin
            for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
                mem_d[i] = mem_q[i + 1];
            end
        end
        if (wr_acc && !bypass) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (wr_idx == CW'(i)) begin
                    mem_d[i] = wr_data;
                end
            end
        end
    end

    // Next occupancy; a bypassed word never occupies an entry.
    always_comb begin
        count_d = count_q;
        if (wr_acc && !rd_acc && !bypass) begin
            count_d = count_q + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - CW'(1);
        end
    end

    // Registered read port: update only when a read is requested.
    always_comb begin
        rd_data_d = rd_data_q;
        rd_val_d  = rd_val_q;
        if (rd_en) begin
            if (rd_acc) begin
                rd_data_d = mem_q[0];
                rd_val_d  = 1'b1;
            end else if (bypass) begin
                rd_data_d = wr_data;
                rd_val_d  = 1'b1;
            end else begin
                rd_val_d  = 1'b0;
            end
        end
    end

    // Sticky error flags; a fresh error in the clearing cycle keeps the flag set.
    always_comb begin
        overflow_d  = (overflow_q && !err_clr) || (wr_en && !wr_ready);
        underflow_d = (underflow_q && !err_clr) || (rd_en && is_empty && !bypass);
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q     <= '0;
            rd_data_q   <= '0;
            rd_val_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            rd_data_q   <= rd_data_d;
            rd_val_q    <= rd_val_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage entries are not reset; an empty count makes them logically invalid.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Output selection: in fall-through mode the head entry is presented
    // directly, forced to zero while empty so stale contents never leak.
    always_comb begin
        count     = count_q;
        overflow  = overflow_q;
        underflow = underflow_q;
        if (FWFT) begin
            rd_val  = !is_empty;
            rd_data = is_empty ? '0 : mem_q[0];
        end else begin
            rd_val  = rd_val_q;
            rd_data = rd_data_q;
        end
    end

endmodule

// File: doc/shift_fifo_thr.md
# shift_fifo_thr

Parametrised shift-register ("shear list") FIFO: storage entries shift toward the head on every pop, so the head is always at entry 0 and no read pointer exists. This generation adds an occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and a selectable first-word-fall-through read mode. It sits between producer/consumer blocks that need a small, shallow buffer with level feedback.

## Interface
- DATA_WIDTH, 8, data bus width (>=1)
- FIFO_DEPTH, 16, number of entries (>=2)
- AFULL_THR, 12, almost_full asserted when count >= AFULL_THR (1..FIFO_DEPTH)
- AEMPTY_THR, 2, almost_empty asserted when count <= AEMPTY_THR (0..FIFO_DEPTH-1)
- FWFT, 0, 0 = registered read, 1 = first-word-fall-through
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- wr_en  in  1  push request
- wr_data  in  DATA_WIDTH  push data
- wr_ready  out  1  count < FIFO_DEPTH
- rd_en  in  1  pop request
- rd_data  out  DATA_WIDTH  popped data (FWFT=0) / head entry (FWFT=1)
- rd_val  out  1  rd_data valid
- count  out  $clog2(FIFO_DEPTH+1)  current occupancy
- almost_full  out  1  count >= AFULL_THR
- almost_empty  out  1  count <= AEMPTY_THR
- overflow  out  1  sticky: push attempted while full
- underflow  out  1  sticky: pop attempted while empty (bypass excluded)
- err_clr  in  1  clears overflow/underflow

## Operation
- Push accepted (wa) = wr_en && wr_ready. wr_ready depends only on registered count; push while full is rejected even if a pop occurs the same cycle.
- Pop accepted (ra) = rd_en && count != 0.
- Bypass (FWFT=0 only): rd_en && wa && count == 0 -> wr_data goes directly to rd_data; nothing stored; count unchanged; no underflow.
- Storage: mem[0] is head. On ra, mem[i] <= mem[i+1] for all i. Write index = count when wa && !ra; count-1 when wa && ra; no write on bypass.
- count: +1 on wa && !ra; -1 on ra && !wa; unchanged otherwise (including bypass).
- FWFT=0: on ra, rd_data <= mem[0], rd_val <= 1; on bypass, rd_data <= wr_data, rd_val <= 1; on rd_en with empty and no wa, rd_val <= 0, rd_data holds. Without rd_en, rd_val and rd_data hold.
- FWFT=1: rd_data = mem[0], rd_val = (count != 0), both combinational from registers; rd_en acts as pop/ack. No bypass; push into empty FIFO is visible the next cycle.
- overflow set on wr_en && !wr_ready; underflow set on rd_en && count == 0 && not bypass. err_clr clears both; a new error in the same cycle wins (flag stays 1).
- almost_full / almost_empty / wr_ready decode combinationally from registered count.

## Timing
- Reset values: count 0, wr_ready 1, rd_val 0, rd_data 0, overflow 0, underflow 0, almost_empty 1, almost_full 0. reset overrides all other inputs; entries are not cleared; contents lost logically.
- Reset asserted mid-stream: next cycle FIFO is empty; pending reads are dropped and no rd_val is produced.
- FWFT=0 read latency 1 cycle from rd_en to rd_val/rd_data. FWFT=1 latency 0 (data at head before rd_en).
- Write-to-readable latency: 1 cycle (entry visible at head the cycle after push); bypass 1 cycle rd_en/wr_en -> rd_val.
- Flags and wr_ready reflect the count after the previous edge; full throughput of one push and one pop per cycle when 0 < count < FIFO_DEPTH.
- Simultaneous push+pop at count == FIFO_DEPTH: pop accepted, push rejected, overflow set, count becomes FIFO_DEPTH-1.

## Test plan
- Reset, then push 0x01..0x10 (DEPTH 16) with no pops -> count 16, wr_ready 0, almost_full 1 from count 12; one more push -> overflow 1, count stays 16.
- Pop 16 times FWFT=0 -> rd_data 0x01..0x10 in order, rd_val 1 each cycle after rd_en; 17th pop -> rd_val 0, underflow 1, almost_empty 1 when count <= 2.
- Empty FIFO, FWFT=0, rd_en && wr_en with wr_data 0xA5 -> next cycle rd_val 1, rd_data 0xA5, count 0, underflow 0.
- count 5, continuous push+pop for 20 cycles with incrementing data -> count stays 5, output order strictly matches input order.
- FWFT=1: push 0x3C into empty -> next cycle rd_val 1, rd_data 0x3C before rd_en; rd_en -> following cycle rd_val 0.
- overflow set, assert err_clr alone -> flag 0; err_clr with concurrent full push -> overflow stays 1; reset mid-fill at count 7 -> count 0, rd_val 0.
